// File: rtl/serialize_pkg.sv
// Shared definitions for the word-to-element serializer.
package serialize_pkg;

   localparam int DEFAULT_W_DATA  = 8;
   localparam int DEFAULT_N_LANES = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Width of a length field able to hold 0..n_lanes inclusive.
   function automatic int f_len_width(input int n_lanes);
      return $clog2(n_lanes + 1);
   endfunction

endpackage

// File: rtl/serialize.sv
// Serializer: accepts a word of N_LANES elements plus a length, emits the
// first len elements one per cycle, tagging the final one with a last flag.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no word held; upstream may present a word
// ST_SEND | word held; elements are being emitted
//
// The last beat can hand over directly to a new word (din ready follows
// dout ready combinationally), so consecutive words stream without bubbles.
// The upstream decouple stage registers its side, which bounds that path.
module serialize
   import serialize_pkg::*;
#(
   parameter int  W_DATA  = DEFAULT_W_DATA,
   parameter int  N_LANES = DEFAULT_N_LANES,
   localparam int W_LEN   = f_len_width(N_LANES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_din_valid,
   output logic                              o_din_ready,
   input  logic [N_LANES*W_DATA+W_LEN-1:0]   i_din_data,
   output logic                              o_dout_valid,
   input  logic                              i_dout_ready,
   output logic [W_DATA:0]                   o_dout_data
);

   localparam int              W_IDX   = $clog2(N_LANES);
   localparam logic [W_LEN-1:0] LEN_MAX = W_LEN'(N_LANES);
   localparam logic [W_LEN-1:0] LEN_ONE = W_LEN'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [W_IDX-1:0]    r_idx;
   logic [W_LEN-1:0]    r_len;
   logic [W_DATA-1:0]   r_lanes [N_LANES];

   logic [W_LEN-1:0]    w_len_raw;
   logic [W_LEN-1:0]    w_len_in;
   logic                w_last;
   logic                w_din_fire;
   logic                w_dout_fire;
   logic                w_capture;

   // Incoming length, clamped to the number of lanes actually present.
   assign w_len_raw = i_din_data[N_LANES*W_DATA +: W_LEN];
   assign w_len_in  = (w_len_raw > LEN_MAX) ? LEN_MAX : w_len_raw;

   // r_len is never zero while in ST_SEND, so len-1 cannot underflow there.
   assign w_last      = (W_LEN'(r_idx) == (r_len - LEN_ONE));
   assign w_din_fire  = i_din_valid && o_din_ready;
   assign w_dout_fire = o_dout_valid && i_dout_ready;
   // A zero-length word is accepted but never loaded.
   assign w_capture   = w_din_fire && (w_len_in != '0);

   assign o_dout_data = {w_last, r_lanes[r_idx]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_dout_fire && w_last) begin
               w_state_nxt = w_capture ? ST_SEND : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs; din ready is held low throughout reset.
   always_comb begin
      o_dout_valid = (r_state == ST_SEND);
      o_din_ready  = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: o_din_ready = 1'b1;
            ST_SEND: o_din_ready = w_last && i_dout_ready;
            default: o_din_ready = 1'b0;
         endcase
      end
   end

   // Element index: restarts on every captured word, advances per beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_capture) begin
         r_idx <= '0;
      end else if (w_dout_fire && !w_last) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // Word payload and length; no reset needed, only read while in ST_SEND.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_len <= w_len_in;
         for (int i = 0; i < N_LANES; i++) begin
            r_lanes[i] <= i_din_data[i*W_DATA +: W_DATA];
         end
      end
   end

endmodule
